// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter
//   Shares the single program-memory port between the CPU fetch stage and a
//   byte-serial loader. A load stalls the CPU, waits DRAIN_CYCLES for the
//   pipeline to drain, packs incoming bytes little-endian into 32-bit words
//   written from address 0 upward, then releases the CPU with a flush.
//
//   Optional build macro: IMEM_LOAD_CHECKSUM_EN
//     defined   -> checksum output is the XOR of every byte accepted in LOAD
//     undefined -> no checksum register; checksum output is 8'h00
//
//   Loader handshake: byte_stb is a plain strobe, not valid/ready. Each
//   rising edge of byte_stb (seen as byte_stb=1 while its registered copy is
//   0) delivers byte_in in that same cycle. There is no backpressure; edges
//   outside LOAD are dropped without being counted.
//
//   dbg_state exposes the FSM state for checkers: 0=RUN 1=DRAIN 2=LOAD 3=RELEASE.
module imem_load_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [7:0]        byte_in,
    input  logic              byte_stb,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              cpu_stall,
    output logic              cpu_flush,
    output logic              load_busy,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic [7:0]        checksum,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // Memory capacity in words, sized to compare against word_count.
    localparam logic [ADDR_W:0]   WORDS_LP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [1:0]          k_q, k_d;
    logic [31:0]         asm_q, asm_d;
    logic                stb_q, stb_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                overflow_q, overflow_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]          cks_q, cks_d;
`endif

    logic stb_pulse;
    logic word_done;

    assign stb_pulse = byte_stb & ~stb_q;
    // The fourth byte of a word arriving in LOAD; a write (or overflow) follows.
    assign word_done = (state_q == ST_LOAD) && stb_pulse && (k_q == 2'd3);

    // Next-state, load datapath and bookkeeping.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        waddr_d      = waddr_q;
        k_d          = k_q;
        asm_d        = asm_q;
        stb_d        = byte_stb;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
        cks_d        = cks_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (load_req) begin
                    state_d      = ST_DRAIN;
                    drain_cnt_d  = CNT_W'(DRAIN_CYCLES - 1);
                    waddr_d      = '0;
                    k_d          = 2'd0;
                    asm_d        = 32'd0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    cks_d        = 8'h00;
`endif
                end
            end
            ST_DRAIN: begin
                if (!load_req) begin
                    state_d = ST_RELEASE;
                end else if (drain_cnt_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (stb_pulse) begin
                    asm_d[{k_q, 3'b000} +: 8] = byte_in;
                    k_d = k_q + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    cks_d = cks_q ^ byte_in;
`endif
                    if (k_q == 2'd3) begin
                        if (word_count_q < WORDS_LP) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = asm_d;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                // Bookkeeping for the write being driven this cycle.
                if (mem_we_q) begin
                    word_count_d = word_count_q + (ADDR_W + 1)'(1);
                    if (waddr_q != ADDR_MAX) begin
                        waddr_d = waddr_q + ADDR_W'(1);
                    end
                end
                // Never abandon a write that is scheduled or in flight.
                if (!load_req && !mem_we_q && !word_done) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
                k_d     = 2'd0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= '0;
            waddr_q      <= '0;
            k_q          <= 2'd0;
            asm_q        <= 32'd0;
            stb_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'd0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            cks_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            waddr_q      <= waddr_d;
            k_q          <= k_d;
            asm_q        <= asm_d;
            stb_q        <= stb_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            cks_q        <= cks_d;
`endif
        end
    end

    // Fetch passes straight through only in RUN; otherwise the loader owns the port.
    assign mem_addr   = (state_q == ST_RUN) ? fetch_addr : waddr_q;
    assign mem_re     = (state_q == ST_RUN) && fetch_req;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_stall  = (state_q != ST_RUN);
    assign cpu_flush  = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
    assign load_busy  = (state_q == ST_LOAD);
    assign word_count = word_count_q;
    assign overflow   = overflow_q;
    assign dbg_state  = state_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    assign checksum   = cks_q;
`else
    assign checksum   = 8'h00;
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: a default instance (ADDR_W=6) and a small
// instance (ADDR_W=2) share all loader/fetch stimulus. Expected writes, word
// counts, overflow and checksum come from a transaction-level model of the
// bytes sent during LOAD.
module tb_imem_load_arbiter;

    localparam int AW      = 6;
    localparam int AWS     = 2;
    localparam int WORDS   = 1 << AW;
    localparam int WORDS_S = 1 << AWS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          load_req;
    logic [7:0]    byte_in;
    logic          byte_stb;
    logic [AW-1:0] fetch_addr;
    logic          fetch_req;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we, mem_re, cpu_stall, cpu_flush, load_busy, overflow;
    logic [AW:0]   word_count;
    logic [7:0]    checksum;
    logic [1:0]    dbg_state;

    logic [AWS-1:0] mem_addr_s;
    logic [31:0]    mem_wdata_s;
    logic           mem_we_s, mem_re_s, cpu_stall_s, cpu_flush_s, load_busy_s, overflow_s;
    logic [AWS:0]   word_count_s;
    logic [7:0]     checksum_s;
    logic [1:0]     dbg_state_s;

    imem_load_arbiter #(.ADDR_W(AW), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_in(byte_in),
        .byte_stb(byte_stb), .fetch_addr(fetch_addr), .fetch_req(fetch_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .cpu_stall(cpu_stall), .cpu_flush(cpu_flush), .load_busy(load_busy),
        .word_count(word_count), .overflow(overflow), .checksum(checksum),
        .dbg_state(dbg_state)
    );

    imem_load_arbiter #(.ADDR_W(AWS), .DRAIN_CYCLES(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_in(byte_in),
        .byte_stb(byte_stb), .fetch_addr(fetch_addr[AWS-1:0]), .fetch_req(fetch_req),
        .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_we(mem_we_s), .mem_re(mem_re_s),
        .cpu_stall(cpu_stall_s), .cpu_flush(cpu_flush_s), .load_busy(load_busy_s),
        .word_count(word_count_s), .overflow(overflow_s), .checksum(checksum_s),
        .dbg_state(dbg_state_s)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [37:0] exp_q[$];
    logic [37:0] exp_s_q[$];
    logic [37:0] act_q[$];
    logic [37:0] act_s_q[$];
    logic [7:0]  tx_q[$];

    int          exp_wc, exp_wc_s;
    logic        exp_ov, exp_ov_s;
    logic [7:0]  exp_cks;
    logic [31:0] exp_wdata   = 32'd0;
    logic [31:0] exp_wdata_s = 32'd0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Write monitors: every cycle with mem_we high is one recorded write.
    always @(negedge clk) begin
        if (rst_n && mem_we)   act_q.push_back({mem_addr, mem_wdata});
        if (rst_n && mem_we_s) act_s_q.push_back({4'b0000, mem_addr_s, mem_wdata_s});
    end

    // ---------------- reference model ----------------
    // Bytes accepted in LOAD form words 4 at a time; the first WORDS are
    // written to 0,1,2...; any further complete word sets overflow.
    task automatic build_model();
        int nwords;
        logic [31:0] w;
        nwords   = tx_q.size() / 4;
        exp_wc   = (nwords > WORDS)   ? WORDS   : nwords;
        exp_wc_s = (nwords > WORDS_S) ? WORDS_S : nwords;
        exp_ov   = (nwords > WORDS);
        exp_ov_s = (nwords > WORDS_S);
        for (int i = 0; i < nwords; i++) begin
            w = {tx_q[4*i+3], tx_q[4*i+2], tx_q[4*i+1], tx_q[4*i]};
            if (i < WORDS) begin
                exp_q.push_back({6'(i), w});
                exp_wdata = w;
            end
            if (i < WORDS_S) begin
                exp_s_q.push_back({6'(i), w});
                exp_wdata_s = w;
            end
        end
        exp_cks = 8'h00;
`ifdef IMEM_LOAD_CHECKSUM_EN
        foreach (tx_q[i]) exp_cks = exp_cks ^ tx_q[i];
`endif
    endtask

    task automatic compare_writes();
        while (exp_q.size() > 0) begin
            if (act_q.size() == 0) begin
                check_val("wr_missing", 64'(exp_q.pop_front()), 64'h1_0000_0000_00);
            end else begin
                check_val("wr", 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
            end
        end
        check_val("wr_extra", 64'(act_q.size()), 64'd0);
        while (exp_s_q.size() > 0) begin
            if (act_s_q.size() == 0) begin
                check_val("wr_s_missing", 64'(exp_s_q.pop_front()), 64'h1_0000_0000_00);
            end else begin
                check_val("wr_s", 64'(act_s_q.pop_front()), 64'(exp_s_q.pop_front()));
            end
        end
        check_val("wr_s_extra", 64'(act_s_q.size()), 64'd0);
        act_q.delete();
        act_s_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        byte_in  = b;
        byte_stb = 1'b1;
        repeat (hold) tick();
        byte_stb = 1'b0;
        byte_in  = 8'($urandom);
        repeat (1 + gap) tick();
    endtask

    // Raise load_req from RUN and walk through the three DRAIN cycles.
    task automatic enter_load(input bit drain_stb);
        check_val("run_stall", cpu_stall, 1'b0);
        load_req = 1'b1;
        tick();
        check_val("drain_stall", cpu_stall, 1'b1);
        check_val("drain_re", mem_re, 1'b0);
        check_val("drain_busy", load_busy, 1'b0);
        if (drain_stb) begin
            byte_in  = 8'($urandom);
            byte_stb = 1'b1;
        end
        tick();
        byte_stb = 1'b0;
        check_val("drain_busy2", load_busy, 1'b0);
        tick();
        check_val("drain_busy3", load_busy, 1'b0);
        tick();
        check_val("load_busy", load_busy, 1'b1);
        check_val("load_flush", cpu_flush, 1'b1);
        check_val("load_wc0", word_count, 64'd0);
    endtask

    task automatic session(input bit drain_stb);
        fetch_req  = 1'b1;
        fetch_addr = AW'($urandom);
        enter_load(drain_stb);
        foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(1, 2), $urandom_range(0, 1));
        tick();
        build_model();
        check_val("wc", word_count, 64'(exp_wc));
        check_val("ov", overflow, exp_ov);
        check_val("cks", checksum, exp_cks);
        check_val("wc_s", word_count_s, 64'(exp_wc_s));
        check_val("ov_s", overflow_s, exp_ov_s);
        load_req = 1'b0;
        tick();
        check_val("rel_stall", cpu_stall, 1'b1);
        check_val("rel_flush", cpu_flush, 1'b1);
        check_val("rel_busy", load_busy, 1'b0);
        tick();
        check_val("run_stall", cpu_stall, 1'b0);
        check_val("run_flush", cpu_flush, 1'b0);
        check_val("run_addr", mem_addr, fetch_addr);
        check_val("run_re", mem_re, 1'b1);
        check_val("hold_wc", word_count, 64'(exp_wc));
        check_val("hold_ov", overflow, exp_ov);
        check_val("hold_ov_s", overflow_s, exp_ov_s);
        check_val("wdata", mem_wdata, exp_wdata);
        check_val("wdata_s", mem_wdata_s, exp_wdata_s);
        compare_writes();
        tx_q.delete();
    endtask

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        load_req   = 1'b0;
        byte_in    = 8'h00;
        byte_stb   = 1'b0;
        fetch_addr = '0;
        fetch_req  = 1'b0;
        repeat (3) tick();
        check_val("rst_stall", cpu_stall, 1'b0);
        check_val("rst_flush", cpu_flush, 1'b0);
        check_val("rst_we", mem_we, 1'b0);
        check_val("rst_wdata", mem_wdata, 32'd0);
        check_val("rst_busy", load_busy, 1'b0);
        check_val("rst_wc", word_count, 64'd0);
        check_val("rst_ov", overflow, 1'b0);
        check_val("rst_cks", checksum, 8'h00);
        rst_n = 1'b1;
        tick();

        // Fetch pass-through
        fetch_req  = 1'b1;
        fetch_addr = AW'(5);
        #1;
        check_val("pt_addr", mem_addr, 64'd5);
        check_val("pt_re", mem_re, 1'b1);
        check_val("pt_we", mem_we, 1'b0);
        check_val("pt_stall", cpu_stall, 1'b0);
        for (int i = 0; i < 6; i++) begin
            fetch_addr = AW'($urandom);
            fetch_req  = 1'($urandom);
            tick();
            check_val("pt_rnd_addr", mem_addr, fetch_addr);
            check_val("pt_rnd_re", mem_re, fetch_req);
            check_val("pt_rnd_addr_s", mem_addr_s, fetch_addr[AWS-1:0]);
        end

        // Directed two-word load with a strobe during DRAIN
        tx_q = {8'h13, 8'h00, 8'h50, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        session(1'b1);

        // Six bytes: one word plus a discarded partial
        fill_random(6);
        session(1'b0);

        // 21 words plus two bytes: small instance overflows
        fill_random(86);
        session(1'b1);

        // Random-length loads
        for (int s = 0; s < 3; s++) begin
            fill_random($urandom_range(0, 40));
            session(1'($urandom));
        end

        // Default instance overflows: 66 words plus one byte
        fill_random(265);
        session(1'b0);

        // Abort during DRAIN: straight to RELEASE, counters cleared on entry
        load_req = 1'b1;
        tick();
        check_val("abort_stall", cpu_stall, 1'b1);
        load_req = 1'b0;
        tick();
        check_val("abort_flush", cpu_flush, 1'b1);
        check_val("abort_busy", load_busy, 1'b0);
        check_val("abort_wc", word_count, 64'd0);
        check_val("abort_ov", overflow, 1'b0);
        tick();
        check_val("abort_run", cpu_stall, 1'b0);
        compare_writes();

        // Asynchronous reset after one word plus two bytes
        fill_random(6);
        enter_load(1'b0);
        foreach (tx_q[i]) send_byte(tx_q[i], 1, $urandom_range(0, 1));
        build_model();
        check_val("prerst_wc", word_count, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_wdata   = 32'd0;
        exp_wdata_s = 32'd0;
        check_val("arst_stall", cpu_stall, 1'b0);
        check_val("arst_flush", cpu_flush, 1'b0);
        check_val("arst_busy", load_busy, 1'b0);
        check_val("arst_we", mem_we, 1'b0);
        check_val("arst_wc", word_count, 64'd0);
        check_val("arst_wdata", mem_wdata, 32'd0);
        check_val("arst_cks", checksum, 8'h00);
        load_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        compare_writes();
        tx_q.delete();

        // Recovery load after reset
        fill_random(8);
        session(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
